// File: rtl/div_seq.sv
// div_seq: EX-stage sequencer for the shared iterative radix-2 divider.
// Latches a DIV/DIVU request, stalls EX until the divider answers, then writes HI/LO once.
module div_seq #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     op1_i,
    input  logic [DATA_W-1:0]     op2_i,
    input  logic                  flush_i,
    input  logic                  div_ready_i,
    input  logic [2*DATA_W-1:0]   div_result_i,
    output logic                  div_start_o,
    output logic                  div_signed_o,
    output logic [DATA_W-1:0]     div_op1_o,
    output logic [DATA_W-1:0]     div_op2_o,
    output logic                  div_annul_o,
    output logic                  stallreq_o,
    output logic                  whilo_o,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
    output logic                  dbz_o,
    output logic                  err_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StBusy  = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;
    localparam logic [1:0] StDrain = 2'd3;

    // Last BUSY cycle the watchdog tolerates; expiry fires in that cycle.
    localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [1:0]        r_drain_cnt;
    logic [7:0]        r_wd;
    logic              r_start;
    logic              r_signed;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              r_dbz;
    logic              r_err;

    logic [1:0]        w_state_nxt;
    logic [1:0]        w_drain_nxt;
    logic              w_idle;
    logic              w_busy;
    logic              w_done;
    logic              w_drain;
    logic              w_accept;
    logic              w_capture;
    logic              w_wd_expire;
    logic              w_abort;

    assign w_idle  = (r_state == StIdle);
    assign w_busy  = (r_state == StBusy);
    assign w_done  = (r_state == StDone);
    assign w_drain = (r_state == StDrain);

    assign w_accept    = w_idle & req_i & ~flush_i;
    // Flush beats ready; a result arriving on the last tolerated cycle still wins the watchdog.
    assign w_capture   = w_busy & ~flush_i & div_ready_i;
    assign w_wd_expire = w_busy & ~flush_i & ~div_ready_i & (r_wd == WdLast);
    assign w_abort     = w_busy & (flush_i | w_wd_expire);

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_nxt = StBusy;
                end
            end
            StBusy: begin
                if (w_abort) begin
                    w_state_nxt = StDrain;
                    w_drain_nxt = 2'd0;
                end else if (w_capture) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                // Two idle cycles let the divider walk back to free with ready clear.
                if (r_drain_cnt == 2'd1) begin
                    w_state_nxt = StIdle;
                    w_drain_nxt = 2'd0;
                end else begin
                    w_drain_nxt = r_drain_cnt + 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_drain_cnt <= 2'd0;
            r_wd        <= 8'd0;
            r_start     <= 1'b0;
            r_signed    <= 1'b0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_dbz       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
            r_err       <= w_wd_expire;

            if (w_accept) begin
                r_signed <= signed_i;
                r_op1    <= op1_i;
                r_op2    <= op2_i;
                r_start  <= 1'b1;
                r_wd     <= 8'd0;
            end else if (w_busy) begin
                r_wd <= r_wd + 8'd1;
            end

            if (w_abort || w_capture) begin
                r_start <= 1'b0;
            end

            if (w_capture) begin
                r_hi  <= div_result_i[2*DATA_W-1:DATA_W];
                r_lo  <= div_result_i[DATA_W-1:0];
                r_dbz <= (r_op2 == '0);
            end
        end
    end

    assign div_start_o  = r_start;
    assign div_signed_o = r_signed;
    assign div_op1_o    = r_op1;
    assign div_op2_o    = r_op2;
    assign div_annul_o  = w_abort;
    assign stallreq_o   = w_accept | w_busy | (w_drain & req_i);
    assign whilo_o      = w_done & ~flush_i;
    assign hi_o         = r_hi;
    assign lo_o         = r_lo;
    assign dbz_o        = r_dbz;
    assign err_o        = r_err;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: randomized self-checking bench for div_seq with a behavioural divider
// (N=35 cycles for a nonzero divisor, N=3 for divisor 0) and an arithmetic reference model.
module tb_div_seq;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_i = 1'b0;
    logic           signed_i = 1'b0;
    logic [W-1:0]   op1_i = '0;
    logic [W-1:0]   op2_i = '0;
    logic           flush_i = 1'b0;
    logic           div_ready_i;
    logic [2*W-1:0] div_result_i;
    logic           div_start_o;
    logic           div_signed_o;
    logic [W-1:0]   div_op1_o;
    logic [W-1:0]   div_op2_o;
    logic           div_annul_o;
    logic           stallreq_o;
    logic           whilo_o;
    logic [W-1:0]   hi_o;
    logic [W-1:0]   lo_o;
    logic           dbz_o;
    logic           err_o;

    int checks = 0;
    int errors = 0;

    logic         model_en = 1'b1;
    logic         force_ready = 1'b0;
    int           m_cnt;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    always #5 clk = ~clk;

    div_seq #(.DATA_W(W), .TIMEOUT(63)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .signed_i     (signed_i),
        .op1_i        (op1_i),
        .op2_i        (op2_i),
        .flush_i      (flush_i),
        .div_ready_i  (div_ready_i),
        .div_result_i (div_result_i),
        .div_start_o  (div_start_o),
        .div_signed_o (div_signed_o),
        .div_op1_o    (div_op1_o),
        .div_op2_o    (div_op2_o),
        .div_annul_o  (div_annul_o),
        .stallreq_o   (stallreq_o),
        .whilo_o      (whilo_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .dbz_o        (dbz_o),
        .err_o        (err_o)
    );

    // {remainder, quotient}; divide by zero yields all zeros.
    function automatic logic [2*W-1:0] ref_div(input logic sgn, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic signed [W-1:0] sa, sb, sq, sr;
        if (b == '0) return '0;
        if (sgn) begin
            sa = a;
            sb = b;
            sq = sa / sb;
            sr = sa % sb;
            return {sr, sq};
        end
        return {a % b, a / b};
    endfunction

    // Behavioural divider: counts cycles since start rose, ready once N cycles have elapsed.
    always @(posedge clk) begin
        if (rst || !div_start_o) m_cnt <= 0;
        else                     m_cnt <= m_cnt + 1;
    end

    assign div_ready_i = force_ready |
                         (model_en & div_start_o & (m_cnt >= ((div_op2_o == '0) ? 3 : 35)));
    assign div_result_i = force_ready ? 64'hA5A5_0000_5A5A_FFFF
                                      : ref_div(div_signed_o, div_op1_o, div_op2_o);

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            req_i = 1'b0;
            flush_i = 1'b0;
        end
    endtask

    // Issue one request and follow it to the write-back cycle. Returns sampling the DONE cycle
    // with req_i still high; fd flushes during DONE; keep leaves req_i high for a follow-on.
    task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic fd, input logic keep, input string tag);
        logic [2*W-1:0] exp;
        int             n, stalls, start_at, start_cnt;
        logic           early_w;
        exp = ref_div(sgn, a, b);
        n = (b == '0) ? 3 : 35;
        stalls = 0;
        start_at = -1;
        start_cnt = 0;
        early_w = 1'b0;
        @(posedge clk); #1;
        req_i = 1'b1; signed_i = sgn; op1_i = a; op2_i = b; flush_i = 1'b0;
        #1;
        while (stallreq_o && stalls < 200) begin
            if (div_start_o && start_at < 0) start_at = stalls;
            if (div_start_o) start_cnt++;
            if (whilo_o) early_w = 1'b1;
            stalls++;
            @(posedge clk); #2;
        end
        checks++;
        if (stalls !== n + 2) begin
            $display("FAIL %s stall_len got %0d want %0d", tag, stalls, n + 2); errors++;
        end
        checks++;
        if (start_at !== 1 || start_cnt !== n + 1) begin
            $display("FAIL %s start_timing got at=%0d len=%0d want at=1 len=%0d",
                     tag, start_at, start_cnt, n + 1); errors++;
        end
        checks++;
        if (early_w !== 1'b0) begin
            $display("FAIL %s whilo_during_stall got 1 want 0", tag); errors++;
        end
        if (fd) begin
            flush_i = 1'b1;
            #1;
            checks++;
            if (whilo_o !== 1'b0) begin
                $display("FAIL %s whilo_flushed got %b want 0", tag, whilo_o); errors++;
            end
        end else begin
            checks++;
            if (whilo_o !== 1'b1) begin
                $display("FAIL %s whilo got %b want 1", tag, whilo_o); errors++;
            end
        end
        checks++;
        if (hi_o !== exp[2*W-1:W] || lo_o !== exp[W-1:0] || dbz_o !== (b == '0)) begin
            $display("FAIL %s result got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b", tag,
                     hi_o, lo_o, dbz_o, exp[2*W-1:W], exp[W-1:0], (b == '0)); errors++;
        end
        exp_hi = exp[2*W-1:W];
        exp_lo = exp[W-1:0];
        if (!keep) begin
            @(posedge clk); #1;
            req_i = 1'b0; flush_i = 1'b0;
            #1;
            checks++;
            if (whilo_o !== 1'b0 || hi_o !== exp_hi || lo_o !== exp_lo) begin
                $display("FAIL %s after_done got whilo=%b hi=%h lo=%h want 0 %h %h", tag,
                         whilo_o, hi_o, lo_o, exp_hi, exp_lo); errors++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({div_start_o, div_signed_o, whilo_o, dbz_o, err_o, stallreq_o, div_annul_o} !== 7'b0
            || div_op1_o !== '0 || div_op2_o !== '0 || hi_o !== '0 || lo_o !== '0) begin
            $display("FAIL reset_state got start=%b whilo=%b hi=%h lo=%h op1=%h want zeros",
                     div_start_o, whilo_o, hi_o, lo_o, div_op1_o); errors++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_div(1'b0, 32'd100, 32'd7, 1'b0, 1'b0, "divu_100_7");
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div_m7_2");
        run_div(1'b0, 32'd5, 32'd0, 1'b0, 1'b0, "divu_5_0");
    endtask

    task automatic test_idle_flush();
        @(posedge clk); #1;
        req_i = 1'b1; flush_i = 1'b1; op1_i = 32'd8; op2_i = 32'd2;
        #1;
        checks++;
        if (stallreq_o !== 1'b0) begin
            $display("FAIL idle_flush_stall got %b want 0", stallreq_o); errors++;
        end
        @(posedge clk); #2;
        checks++;
        if (div_start_o !== 1'b0) begin
            $display("FAIL idle_flush_start got %b want 0", div_start_o); errors++;
        end
        idle_cycles(1);
    endtask

    task automatic test_flush_busy();
        int busy;
        logic hit;
        busy = 0;
        hit = 1'b0;
        @(posedge clk); #1;
        req_i = 1'b1; signed_i = 1'b0; op1_i = 32'd100; op2_i = 32'd7; flush_i = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(posedge clk); #1;
            if (div_start_o) busy++;
            if (busy == 10) begin
                hit = 1'b1;
                flush_i = 1'b1;
                #1;
                checks++;
                if (div_annul_o !== 1'b1 || whilo_o !== 1'b0) begin
                    $display("FAIL flush_annul got annul=%b whilo=%b want 1 0",
                             div_annul_o, whilo_o); errors++;
                end
            end
        end
        checks++;
        if (!hit) begin
            $display("FAIL flush_reach_busy got busy=%0d want 10", busy); errors++;
        end
        // Next instruction holds req high through the drain.
        for (int d = 0; d < 2; d++) begin
            @(posedge clk); #1;
            flush_i = 1'b0; op1_i = 32'd20; op2_i = 32'd3;
            #1;
            checks++;
            if (stallreq_o !== 1'b1 || div_start_o !== 1'b0 || div_annul_o !== 1'b0 ||
                whilo_o !== 1'b0) begin
                $display("FAIL drain_%0d got stall=%b start=%b annul=%b whilo=%b want 1 0 0 0",
                         d, stallreq_o, div_start_o, div_annul_o, whilo_o); errors++;
            end
        end
        run_div(1'b0, 32'd20, 32'd3, 1'b0, 1'b0, "after_drain");
    endtask

    task automatic test_watchdog();
        int   busy, errs, err_busy;
        logic last_annul, wrote;
        busy = 0; errs = 0; err_busy = -1; last_annul = 1'b0; wrote = 1'b0;
        model_en = 1'b0;
        @(posedge clk); #1;
        req_i = 1'b1; signed_i = 1'b0; op1_i = 32'd9; op2_i = 32'd4; flush_i = 1'b0;
        for (int i = 0; i < 90; i++) begin
            #1;
            if (div_start_o) begin
                busy++;
                last_annul = div_annul_o;
            end else if (busy > 0) begin
                req_i = 1'b0;
            end
            if (err_o) begin
                errs++;
                err_busy = div_start_o ? -2 : busy;
            end
            if (whilo_o) wrote = 1'b1;
            @(posedge clk); #1;
        end
        model_en = 1'b1;
        checks++;
        if (busy !== 63 || last_annul !== 1'b1) begin
            $display("FAIL wd_busy got busy=%0d annul=%b want 63 1", busy, last_annul); errors++;
        end
        checks++;
        if (errs !== 1 || err_busy !== 63) begin
            $display("FAIL wd_err got pulses=%0d at=%0d want 1 at 63", errs, err_busy); errors++;
        end
        checks++;
        if (wrote !== 1'b0 || hi_o !== exp_hi || lo_o !== exp_lo) begin
            $display("FAIL wd_no_write got whilo=%b hi=%h lo=%h want 0 %h %h",
                     wrote, hi_o, lo_o, exp_hi, exp_lo); errors++;
        end
        run_div(1'b0, 32'd9, 32'd4, 1'b0, 1'b0, "after_wd");
    endtask

    task automatic test_stray_ready();
        logic bad;
        bad = 1'b0;
        force_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            if (whilo_o || stallreq_o || hi_o !== exp_hi || lo_o !== exp_lo) bad = 1'b1;
        end
        force_ready = 1'b0;
        checks++;
        if (bad) begin
            $display("FAIL stray_ready got hi=%h lo=%h want %h %h", hi_o, lo_o, exp_hi, exp_lo);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        run_div(1'b0, 32'd1000, 32'd9, 1'b0, 1'b1, "b2b_first");
        run_div(1'b0, 32'd77, 32'd5, 1'b0, 1'b0, "b2b_second");
        run_div(1'b1, 32'd50, 32'd6, 1'b1, 1'b0, "done_flush");
    endtask

    task automatic test_random();
        logic         sgn;
        logic [W-1:0] a, b;
        for (int i = 0; i < 14; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = $urandom_range(1, 300);
                default: b = $urandom;
            endcase
            if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            run_div(sgn, a, b, 1'b0, 1'b0, "random");
        end
    endtask

    task automatic test_mid_reset();
        @(posedge clk); #1;
        req_i = 1'b1; signed_i = 1'b1; op1_i = 32'd50; op2_i = 32'd5;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1; req_i = 1'b0;
        @(posedge clk); #2;
        checks++;
        if ({div_start_o, div_signed_o, whilo_o, dbz_o, err_o, stallreq_o, div_annul_o} !== 7'b0
            || div_op1_o !== '0 || div_op2_o !== '0 || hi_o !== '0 || lo_o !== '0) begin
            $display("FAIL mid_reset got start=%b signed=%b op1=%h hi=%h lo=%h want zeros",
                     div_start_o, div_signed_o, div_op1_o, hi_o, lo_o); errors++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        run_div(1'b0, 32'd64, 32'd8, 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_idle_flush();
        test_flush_busy();
        test_watchdog();
        test_stray_ready();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
